// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the UART parity engine:
//   - PAR_* : 2-bit parity-type encodings (even, odd, mark, space)
//   - chk_state_e : serial checker FSM states
//   - par_of() : parity rule applied to a (zero-extended) data word
// ---------------------------------------------------------------------------
package parity_pkg;

  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_MARK  = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  // Widest legal frame; narrower words are zero-extended, which leaves
  // their XOR-reduction unchanged.
  localparam int MAX_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } chk_state_e;

  function automatic logic par_of(input logic [MAX_DATA_WIDTH-1:0] data,
                                  input logic [1:0]                ptype);
    logic p;
    case (ptype)
      PAR_EVEN: p = ^data;
      PAR_ODD:  p = ~^data;
      PAR_MARK: p = 1'b1;
      default:  p = 1'b0;  // PAR_SPACE
    endcase
    return p;
  endfunction

endpackage

// File: rtl/parity_checker.sv
// ---------------------------------------------------------------------------
// parity_checker
// Serial RX parity checker. A frame starts on chk_start, accumulates the XOR
// of DATA_WIDTH sampled bits, then (if parity is enabled) compares the
// received parity bit against the expected value.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   par_en, par_type    : parity config, latched on chk_start
//   chk_start           : frame start / restart pulse
//   samp_en, samp_bit   : sampled-bit strobe and value
//   chk_busy            : frame in progress (DATA or PAR)
//   chk_done            : 1-cycle pulse, frame check complete
//   par_err             : 1-cycle pulse with chk_done on parity mismatch
// ---------------------------------------------------------------------------
module parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       par_en,
  input  logic [1:0] par_type,
  input  logic       chk_start,
  input  logic       samp_en,
  input  logic       samp_bit,
  output logic       chk_busy,
  output logic       chk_done,
  output logic       par_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  chk_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_q;
  logic             en_q;
  logic [1:0]       type_q;
  logic             done_q;
  logic             err_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      en_q    <= 1'b0;
      type_q  <= PAR_EVEN;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // done/err are single-cycle pulses unless re-asserted below.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (chk_start) begin
        // Start or abort-and-restart from any state; a coincident sample
        // is dropped.
        state_q <= ST_DATA;
        cnt_q   <= '0;
        acc_q   <= 1'b0;
        en_q    <= par_en;
        type_q  <= par_type;
      end else begin
        case (state_q)
          ST_DATA: begin
            if (samp_en) begin
              acc_q <= acc_q ^ samp_bit;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == LAST_IDX) begin
                if (en_q) begin
                  state_q <= ST_PAR;
                end else begin
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
                end
              end
            end
          end
          ST_PAR: begin
            if (samp_en) begin
              err_q   <= (samp_bit != par_of(MAX_DATA_WIDTH'(acc_q), type_q));
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          default: ;  // ST_IDLE: samples ignored
        endcase
      end
    end
  end

  assign chk_busy = (state_q != ST_IDLE);
  assign chk_done = done_q;
  assign par_err  = err_q;

endmodule

// File: rtl/parity_gen_chk.sv
// ---------------------------------------------------------------------------
// parity_gen_chk
// UART parity engine shared by TX and RX paths.
// TX side captures p_data when D_valid && !busy and registers its parity bit
// (config sampled only at capture). RX side is the serial parity_checker.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   p_data, D_valid, busy      : TX word and capture handshake
//   par_en, par_type           : parity enable / type (00 even, 01 odd,
//                                10 mark, 11 space)
//   par_bit, par_bit_vld       : registered TX parity bit and its valid flag
//   chk_start, samp_en,
//   samp_bit                   : RX frame start and sampled-bit stream
//   chk_busy, chk_done, par_err: RX checker status
// ---------------------------------------------------------------------------
module parity_gen_chk
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  D_valid,
  input  logic                  busy,
  input  logic                  par_en,
  input  logic [1:0]            par_type,
  output logic                  par_bit,
  output logic                  par_bit_vld,
  input  logic                  chk_start,
  input  logic                  samp_en,
  input  logic                  samp_bit,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic                  par_err
);

  logic par_bit_q, par_bit_d;
  logic par_vld_q, par_vld_d;
  logic capture;

  assign capture = D_valid && !busy;

  // NOTE: each next-state signal gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    par_bit_d = par_bit_q;
    par_vld_d = par_vld_q;
    if (capture) begin
      par_bit_d = par_en ? par_of(MAX_DATA_WIDTH'(p_data), par_type) : 1'b0;
      par_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit_q <= 1'b0;
      par_vld_q <= 1'b0;
    end else begin
      par_bit_q <= par_bit_d;
      par_vld_q <= par_vld_d;
    end
  end

  assign par_bit     = par_bit_q;
  assign par_bit_vld = par_vld_q;

  parity_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_checker (
    .clk       (clk),
    .reset     (reset),
    .par_en    (par_en),
    .par_type  (par_type),
    .chk_start (chk_start),
    .samp_en   (samp_en),
    .samp_bit  (samp_bit),
    .chk_busy  (chk_busy),
    .chk_done  (chk_done),
    .par_err   (par_err)
  );

endmodule

// File: tb/tb_parity_gen_chk.sv
// ---------------------------------------------------------------------------
// tb_parity_gen_chk
// Self-checking bench: directed cases followed by random stimulus, every
// cycle compared against a frame-level reference model (bit queue + parity
// by population count).
// ---------------------------------------------------------------------------
module tb_parity_gen_chk;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] p_data;
  logic          D_valid;
  logic          busy;
  logic          par_en;
  logic [1:0]    par_type;
  logic          par_bit;
  logic          par_bit_vld;
  logic          chk_start;
  logic          samp_en;
  logic          samp_bit;
  logic          chk_busy;
  logic          chk_done;
  logic          par_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  parity_gen_chk #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .p_data      (p_data),
    .D_valid     (D_valid),
    .busy        (busy),
    .par_en      (par_en),
    .par_type    (par_type),
    .par_bit     (par_bit),
    .par_bit_vld (par_bit_vld),
    .chk_start   (chk_start),
    .samp_en     (samp_en),
    .samp_bit    (samp_bit),
    .chk_busy    (chk_busy),
    .chk_done    (chk_done),
    .par_err     (par_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic m_par, m_vld, m_busy, m_done, m_err;
  logic m_en;
  logic [1:0] m_type;
  bit rx_q[$];

  function automatic logic ref_par(input int ones, input logic [1:0] t);
    case (t)
      2'b00:   return logic'(ones % 2 == 1);
      2'b01:   return logic'(ones % 2 == 0);
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int q_ones();
    int n = 0;
    foreach (rx_q[i]) n += int'(rx_q[i]);
    return n;
  endfunction

  task automatic model_step();
    if (reset) begin
      m_par = 0; m_vld = 0; m_busy = 0; m_done = 0; m_err = 0;
      rx_q.delete();
    end else begin
      if (D_valid && !busy) begin
        m_par = par_en ? ref_par($countones(p_data), par_type) : 1'b0;
        m_vld = 1'b1;
      end
      m_done = 0;
      m_err  = 0;
      if (chk_start) begin
        m_busy = 1; m_en = par_en; m_type = par_type;
        rx_q.delete();
      end else if (m_busy && samp_en) begin
        if (rx_q.size() < DW) begin
          rx_q.push_back(samp_bit);
          if (rx_q.size() == DW && !m_en) begin
            m_done = 1; m_busy = 0;
          end
        end else begin
          m_err  = (samp_bit != ref_par(q_ones(), m_type));
          m_done = 1; m_busy = 0;
        end
      end
    end
  endtask

  // Inputs are driven at negedge; outputs compared 1 time unit after posedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("par_bit",     32'(par_bit),     32'(m_par));
    check("par_bit_vld", 32'(par_bit_vld), 32'(m_vld));
    check("chk_busy",    32'(chk_busy),    32'(m_busy));
    check("chk_done",    32'(chk_done),    32'(m_done));
    check("par_err",     32'(par_err),     32'(m_err));
    @(negedge clk);
  endtask

  task automatic capture(input logic [DW-1:0] d, input logic en, input logic [1:0] t);
    p_data = d; par_en = en; par_type = t; D_valid = 1; busy = 0;
    tick();
    D_valid = 0;
  endtask

  task automatic run_frame(input logic [DW-1:0] d, input logic en, input logic [1:0] t,
                           input logic pbit, input logic exp_err);
    par_en = en; par_type = t;
    chk_start = 1; samp_en = 0;
    tick();
    chk_start = 0;
    check("frm_busy_start", 32'(chk_busy), 32'd1);
    for (int i = 0; i < DW; i++) begin
      samp_en = 1; samp_bit = d[i];
      tick();
      if (i < DW - 1) check("frm_no_early_done", 32'(chk_done), 32'd0);
    end
    if (en) begin
      check("frm_wait_par", 32'(chk_done), 32'd0);
      samp_bit = pbit;
      tick();
    end
    samp_en = 0;
    check("frm_done",  32'(chk_done), 32'd1);
    check("frm_err",   32'(par_err),  32'(exp_err));
    check("frm_idle",  32'(chk_busy), 32'd0);
    tick();
    check("frm_done_1cyc", 32'(chk_done), 32'd0);
  endtask

  initial begin
    reset = 1; p_data = 8'h3C; D_valid = 1; busy = 0; par_en = 1; par_type = 2'b00;
    chk_start = 0; samp_en = 0; samp_bit = 0;
    m_en = 0; m_type = 0;

    // Reset coinciding with D_valid
    tick();
    tick();
    check("rst_par_bit", 32'(par_bit),     32'd0);
    check("rst_vld",     32'(par_bit_vld), 32'd0);
    check("rst_busy",    32'(chk_busy),    32'd0);
    reset = 0; D_valid = 0;
    tick();
    check("idle_vld", 32'(par_bit_vld), 32'd0);

    // Generation side
    capture(8'hA5, 1, 2'b00); check("even_a5", 32'(par_bit), 32'd0);
                              check("even_a5_vld", 32'(par_bit_vld), 32'd1);
    capture(8'h07, 1, 2'b00); check("even_07",  32'(par_bit), 32'd1);
    capture(8'hA5, 1, 2'b01); check("odd_a5",   32'(par_bit), 32'd1);
    capture(8'h00, 1, 2'b10); check("mark_00",  32'(par_bit), 32'd1);
    capture(8'hFF, 1, 2'b11); check("space_ff", 32'(par_bit), 32'd0);
    capture(8'h07, 0, 2'b00); check("dis_07",   32'(par_bit), 32'd0);
    capture(8'hA5, 1, 2'b00); check("even_a5b", 32'(par_bit), 32'd0);
    // Blocked by busy: odd parity of 8'h01 would be 0, even is 1
    p_data = 8'h01; D_valid = 1; busy = 1; par_type = 2'b00;
    tick();
    check("busy_hold", 32'(par_bit), 32'd0);
    busy = 0; D_valid = 0; par_type = 2'b01;
    tick();
    check("cfg_change_hold", 32'(par_bit), 32'd0);
    capture(8'hA5, 1, 2'b01); check("recapture_odd", 32'(par_bit), 32'd1);
    // Back-to-back captures
    p_data = 8'h01; par_type = 2'b00; D_valid = 1; tick();
    check("b2b_1", 32'(par_bit), 32'd1);
    p_data = 8'h03; tick();
    check("b2b_2", 32'(par_bit), 32'd0);
    D_valid = 0;

    // Checker side
    run_frame(8'h5A, 1, 2'b00, 1'b0, 1'b0);
    run_frame(8'h5A, 1, 2'b00, 1'b1, 1'b1);
    run_frame(8'h5A, 1, 2'b01, 1'b1, 1'b0);
    run_frame(8'h5A, 0, 2'b00, 1'b1, 1'b0);
    // Restart after 4 bits
    par_en = 0; chk_start = 1; tick(); chk_start = 0;
    for (int i = 0; i < 4; i++) begin samp_en = 1; samp_bit = 1; tick(); end
    samp_en = 0;
    check("pre_restart_busy", 32'(chk_busy), 32'd1);
    run_frame(8'hC3, 0, 2'b00, 1'b0, 1'b0);
    // Reset mid-frame at cnt=5
    par_en = 1; chk_start = 1; tick(); chk_start = 0;
    for (int i = 0; i < 5; i++) begin samp_en = 1; samp_bit = 1; tick(); end
    reset = 1; D_valid = 1;
    tick();
    check("midrst_busy", 32'(chk_busy),    32'd0);
    check("midrst_done", 32'(chk_done),    32'd0);
    check("midrst_vld",  32'(par_bit_vld), 32'd0);
    reset = 0; D_valid = 0; samp_en = 1;
    tick();
    check("midrst_stay_idle", 32'(chk_busy), 32'd0);
    samp_en = 0;

    // Random phase
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      p_data    = DW'($urandom);
      D_valid   = ($urandom_range(0, 1) == 1);
      busy      = ($urandom_range(0, 9) < 3);
      par_en    = ($urandom_range(0, 4) != 0);
      par_type  = 2'($urandom);
      chk_start = ($urandom_range(0, 39) == 0);
      samp_en   = ($urandom_range(0, 1) == 1);
      samp_bit  = 1'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_gen_chk.md
Name: parity_gen_chk

Overview:
- Parametrised parity engine for the UART path: next generation of the TX parity calculator.
- Generation side latches a DATA_WIDTH-bit word on a valid/busy handshake and produces a registered parity bit. Supported modes: even, odd, mark, space, or disabled.
- Check side accumulates parity over serially sampled RX bits, then compares the received parity bit and flags mismatches.
- Sits between the UART TX serializer/RX deserializer and their FSMs; shared by both directions.

Parameters:
- DATA_WIDTH, 8, frame data bits (legal range 5..16).
- CNT_W, $clog2(DATA_WIDTH+1), checker bit-counter width (derived; not overridden).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p_data  in  DATA_WIDTH  TX parallel data
- D_valid  in  1  TX data valid
- busy  in  1  TX serializer busy; blocks capture
- par_en  in  1  parity enabled
- par_type  in  2  00 even, 01 odd, 10 mark, 11 space
- par_bit  out  1  TX parity bit for last captured word
- par_bit_vld  out  1  par_bit corresponds to a captured word
- chk_start  in  1  RX frame start pulse (after start bit)
- samp_en  in  1  RX sampled-bit strobe
- samp_bit  in  1  RX sampled bit value
- chk_busy  out  1  checker mid-frame
- chk_done  out  1  1-cycle pulse, frame check complete
- par_err  out  1  1-cycle pulse with chk_done, parity mismatch

Behaviour:
- Reset (sync, active-high, sampled at posedge clk):
  - par_bit=0, par_bit_vld=0, chk_busy=0, chk_done=0, par_err=0.
  - Checker FSM returns to IDLE; counter and accumulator are cleared.
  - Reset overrides every other input in the same cycle.
- Parity function f(data,type):
  - even: ^data
  - odd: ~^data
  - mark: 1
  - space: 0
- Generation side:
  - Capture occurs on a posedge where D_valid && !busy.
  - At that edge: par_bit <= par_en ? f(p_data,par_type) : 0, and par_bit_vld <= 1. Latency is 1 cycle.
  - par_en and par_type are sampled only at capture. Later changes do not affect par_bit until the next capture.
  - With no capture, par_bit and par_bit_vld hold their values.
  - Capture is blocked while busy=1. Back-to-back captures on consecutive cycles are legal; each updates par_bit.
- Checker FSM, states IDLE, DATA, PAR:
  - IDLE: on chk_start, latch par_en/par_type, set cnt=0 and acc=0, go to DATA. samp_en is ignored.
  - DATA: on samp_en, acc ^= samp_bit and cnt++.
    - If samp_en arrives with cnt==DATA_WIDTH-1 and latched par_en=1, go to PAR.
    - If samp_en arrives with cnt==DATA_WIDTH-1 and latched par_en=0, pulse chk_done next cycle with par_err=0 and go to IDLE.
  - PAR: on samp_en, par_err <= (samp_bit != f_acc), where f_acc is the f() rule applied to acc and latched par_type. Pulse chk_done and go to IDLE.
  - chk_busy = 1 in DATA and PAR.
  - chk_start in DATA or PAR aborts the frame and restarts it: cnt=0, acc=0, config relatched, stay in DATA, no chk_done.
  - chk_start and samp_en in the same cycle: chk_start wins and the sample is dropped.
  - samp_en without a pending edge has no effect. Counter saturation cannot occur; the state change happens at DATA_WIDTH-1.
- Generation and check sides are independent and may operate in the same cycle.

Decomposition:
- Shared package parity_pkg holds:
  - PAR_EVEN/PAR_ODD/PAR_MARK/PAR_SPACE 2-bit constants
  - checker state encodings ST_IDLE/ST_DATA/ST_PAR
  - pure function par_of(data, type)
- One sub-module, parity_checker, contains the serial FSM, counter and accumulator.
- The top holds the capture/generation logic and instantiates parity_checker.

Test Plan:
- DATA_WIDTH=8, par_en=1, even: capture p_data=8'hA5 -> par_bit=0, par_bit_vld=1 one cycle later. Capture 8'h07 -> par_bit=1.
- odd with 8'hA5 -> par_bit=1. mark with 8'h00 -> 1. space with 8'hFF -> 0. par_en=0 -> par_bit=0.
- busy=1 with D_valid=1, p_data=8'h01 -> par_bit unchanged. Changing par_type after capture -> par_bit unchanged until the next capture.
- Checker, even: chk_start, then 8 samp_en bits of 8'h5A LSB-first, then parity bit 0 -> chk_done pulse, par_err=0. Same frame with parity bit 1 -> par_err=1.
- Checker with par_en=0: 8 bits -> chk_done after the 8th bit, no PAR state, par_err=0. chk_start after 4 bits -> restart; a full 8-bit frame is then required.
- reset asserted mid-frame (DATA, cnt=5) -> next cycle IDLE, chk_busy=0, no chk_done. Outputs all 0 after reset, including when reset coincides with D_valid.
